// File: rtl/apb3_ram_bridge_pkg.sv
// Package: apb3_ram_bridge_pkg
// Shared definitions for the APB3-to-RAM bridge:
//   state_t   - bridge FSM encoding (IDLE=0, CMD=1, RSP=2, ACK=3)
//   RD_MASK   - byte mask driven on every read command
//   ERR_RDATA - PRDATA value returned on an error or abort
package apb3_ram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [3:0]  RD_MASK   = 4'hF;
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/apb3_ram_bridge_timeout.sv
// Module: apb3_ram_bridge_timeout
// Watchdog counter for the bridge's CMD/RSP wait states.
// It is instantiated only when APB3_RAM_BRIDGE_TIMEOUT_EN is defined.
// Ports:
//   io_mainClk            in  system clock, rising edge
//   resetCtrl_systemReset in  asynchronous, active-high reset
//   clear                 in  zero the counter (held while the bridge is idle)
//   enable                in  count one cycle (bridge waiting on the RAM)
//   expire                out high while enabled and the count equals TIMEOUT_CYCLES
module apb3_ram_bridge_timeout
  import apb3_ram_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic io_mainClk,
  input  logic resetCtrl_systemReset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;

  // The count saturates at LIMIT, so expire stays up until the bridge leaves
  // the wait states.
  assign expire = enable && (count == LIMIT);

  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && !expire) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/apb3_ram_bridge.sv
// Module: apb3_ram_bridge
// APB3 slave that turns each APB3 transfer into one command on the RAM's
// cmd/rsp bus. Only one command is outstanding at a time. PREADY and PRDATA
// are registered. An access at or beyond ADDR_DEPTH*4 bytes is answered with
// PSLVERROR, and no command is sent to the RAM.
// Optional feature: when APB3_RAM_BRIDGE_TIMEOUT_EN is defined, a transfer
// that waits in CMD/RSP for TIMEOUT_CYCLES cycles is aborted with PSLVERROR
// and PRDATA=0.
// Ports:
//   io_mainClk, resetCtrl_systemReset   clock and asynchronous active-high reset
//   io_apb_*                            APB3 slave port (PADDR, PSEL, PENABLE, PWRITE,
//                                       PWDATA, PSTRB in; PREADY, PRDATA, PSLVERROR out)
//   io_bus_cmd_*                        RAM command: valid/ready and the payload
//                                       (write, address, data, mask)
//   io_bus_rsp_*                        RAM read response: valid and data
module apb3_ram_bridge
  import apb3_ram_bridge_pkg::*;
#(
  parameter int ADDR_DEPTH     = 65536,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        io_mainClk,
  input  logic        resetCtrl_systemReset,
  input  logic [31:0] io_apb_PADDR,
  input  logic        io_apb_PSEL,
  input  logic        io_apb_PENABLE,
  input  logic        io_apb_PWRITE,
  input  logic [31:0] io_apb_PWDATA,
  input  logic [3:0]  io_apb_PSTRB,
  output logic        io_apb_PREADY,
  output logic [31:0] io_apb_PRDATA,
  output logic        io_apb_PSLVERROR,
  output logic        io_bus_cmd_valid,
  input  logic        io_bus_cmd_ready,
  output logic        io_bus_cmd_payload_write,
  output logic [31:0] io_bus_cmd_payload_address,
  output logic [31:0] io_bus_cmd_payload_data,
  output logic [3:0]  io_bus_cmd_payload_mask,
  input  logic        io_bus_rsp_valid,
  input  logic [31:0] io_bus_rsp_payload_data
);

  // The limit is 33 bits wide so that a full 32-bit byte range can be compared.
  localparam logic [32:0] ADDR_LIMIT = 33'(ADDR_DEPTH) << 2;

  state_t state;
  logic   setup_phase;
  logic   out_of_range;
  logic   timeout_expire;

  assign setup_phase  = io_apb_PSEL && !io_apb_PENABLE;
  assign out_of_range = {1'b0, io_apb_PADDR} >= ADDR_LIMIT;

`ifdef APB3_RAM_BRIDGE_TIMEOUT_EN
  apb3_ram_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .io_mainClk           (io_mainClk),
    .resetCtrl_systemReset(resetCtrl_systemReset),
    .clear                (state == ST_IDLE),
    .enable               ((state == ST_CMD) || (state == ST_RSP)),
    .expire               (timeout_expire)
  );
`else
  // The timeout is not built in, so this is constant 0 and the bridge waits
  // for the RAM indefinitely.
  assign timeout_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) begin
      state                      <= ST_IDLE;
      io_apb_PREADY              <= 1'b0;
      io_apb_PSLVERROR           <= 1'b0;
      io_apb_PRDATA              <= 32'h0;
      io_bus_cmd_valid           <= 1'b0;
      io_bus_cmd_payload_write   <= 1'b0;
      io_bus_cmd_payload_address <= 32'h0;
      io_bus_cmd_payload_data    <= 32'h0;
      io_bus_cmd_payload_mask    <= 4'h0;
    end else begin
      // PREADY/PSLVERROR are set only on entry to ACK, so each lasts one cycle.
      io_apb_PREADY    <= 1'b0;
      io_apb_PSLVERROR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (setup_phase) begin
            io_bus_cmd_payload_write   <= io_apb_PWRITE;
            io_bus_cmd_payload_address <= io_apb_PADDR;
            io_bus_cmd_payload_data    <= io_apb_PWDATA;
            io_bus_cmd_payload_mask    <= io_apb_PWRITE ? io_apb_PSTRB : RD_MASK;
            if (out_of_range) begin
              state            <= ST_ACK;
              io_apb_PREADY    <= 1'b1;
              io_apb_PSLVERROR <= 1'b1;
              io_apb_PRDATA    <= ERR_RDATA;
            end else begin
              state            <= ST_CMD;
              io_bus_cmd_valid <= 1'b1;
            end
          end
        end
        ST_CMD: begin
          // If the RAM accepts in the same cycle the timeout expires, the
          // accept wins because the RAM has already taken the command.
          if (io_bus_cmd_ready) begin
            io_bus_cmd_valid <= 1'b0;
            if (io_bus_cmd_payload_write) begin
              state         <= ST_ACK;
              io_apb_PREADY <= 1'b1;
            end else begin
              state <= ST_RSP;
            end
          end else if (timeout_expire) begin
            io_bus_cmd_valid <= 1'b0;
            state            <= ST_ACK;
            io_apb_PREADY    <= 1'b1;
            io_apb_PSLVERROR <= 1'b1;
            io_apb_PRDATA    <= ERR_RDATA;
          end
        end
        ST_RSP: begin
          if (io_bus_rsp_valid) begin
            io_apb_PRDATA <= io_bus_rsp_payload_data;
            state         <= ST_ACK;
            io_apb_PREADY <= 1'b1;
          end else if (timeout_expire) begin
            state            <= ST_ACK;
            io_apb_PREADY    <= 1'b1;
            io_apb_PSLVERROR <= 1'b1;
            io_apb_PRDATA    <= ERR_RDATA;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_ram_bridge.sv
module tb_apb3_ram_bridge;

  localparam int ADDR_DEPTH = 65536;
  localparam int TO_CYCLES  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  apb3_ram_bridge #(
    .ADDR_DEPTH    (ADDR_DEPTH),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .io_mainClk                (clk),
    .resetCtrl_systemReset     (rst),
    .io_apb_PADDR              (paddr),
    .io_apb_PSEL               (psel),
    .io_apb_PENABLE            (penable),
    .io_apb_PWRITE             (pwrite),
    .io_apb_PWDATA             (pwdata),
    .io_apb_PSTRB              (pstrb),
    .io_apb_PREADY             (pready),
    .io_apb_PRDATA             (prdata),
    .io_apb_PSLVERROR          (pslverr),
    .io_bus_cmd_valid          (cmd_valid),
    .io_bus_cmd_ready          (cmd_ready),
    .io_bus_cmd_payload_write  (cmd_write),
    .io_bus_cmd_payload_address(cmd_addr),
    .io_bus_cmd_payload_data   (cmd_data),
    .io_bus_cmd_payload_mask   (cmd_mask),
    .io_bus_rsp_valid          (rsp_valid),
    .io_bus_rsp_payload_data   (rsp_data)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Environment: cycle counter, cmd_ready schedule, RAM model
  int          cyc      = 0;
  int          ready_at = 1 << 30;
  int          due      = -10;
  int          rsp_lat  = 1;
  logic [31:0] rdat     = 32'h0;
  logic [31:0] ram [0:255];
  logic [31:0] mdl [0:255];

  // Expectations for the transfer currently in progress
  logic        act = 1'b0, chk_en = 1'b1;
  int          t_t0, t_d, t_done;
  logic        t_write, t_err;
  logic [31:0] t_addr, t_data, t_rd;
  logic [3:0]  t_mask;
  logic [31:0] prdata_m = 32'h0;
  int          fires = 0;
  int          last_rdy = -1;

  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      cmd_ready = (cyc >= ready_at);
      rsp_valid = (cyc == due);
      rsp_data  = (cyc == due) ? rdat : 32'hDEAD_BEEF;
    end
  end

  // RAM: writes land on the accepted command; reads answer rsp_lat cycles later
  initial forever begin
    @(negedge clk);
    if (!rst && cmd_valid && cmd_ready) begin
      if (cmd_write) begin
        for (int b = 0; b < 4; b++)
          if (cmd_mask[b]) ram[cmd_addr[9:2]][8*b +: 8] = cmd_data[8*b +: 8];
      end else begin
        rdat = ram[cmd_addr[9:2]];
        due  = cyc + rsp_lat;
      end
    end
  end

  // Compare process: every cycle, check the outputs against the timeline of
  // the current transfer.
  initial forever begin
    logic e_cv, e_rdy;
    @(negedge clk);
    if (chk_en) begin
      if (rst) begin
        prdata_m = 32'h0;
        chk("rst_pready",    32'(pready),    32'h0);
        chk("rst_pslverror", 32'(pslverr),   32'h0);
        chk("rst_prdata",    prdata,         32'h0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst_cmd_addr",  cmd_addr,       32'h0);
        chk("rst_cmd_data",  cmd_data,       32'h0);
        chk("rst_cmd_mask",  32'(cmd_mask),  32'h0);
        chk("rst_cmd_write", 32'(cmd_write), 32'h0);
      end else begin
        e_cv  = act && !t_err && (cyc >= t_t0 + 1) && (cyc <= t_t0 + 1 + t_d);
        e_rdy = act && (cyc == t_done);
        if (e_rdy) prdata_m = t_err ? 32'h0 : (t_write ? prdata_m : t_rd);
        chk("cmd_valid", 32'(cmd_valid), 32'(e_cv));
        chk("pready",    32'(pready),    32'(e_rdy));
        chk("pslverror", 32'(pslverr),   32'(e_rdy && t_err));
        chk("prdata",    prdata,         prdata_m);
        if (e_cv) begin
          chk("cmd_addr",  cmd_addr,       t_addr);
          chk("cmd_write", 32'(cmd_write), 32'(t_write));
          chk("cmd_data",  cmd_data,       t_data);
          chk("cmd_mask",  32'(cmd_mask),  32'(t_mask));
        end
        if (cmd_valid && cmd_ready) fires++;
        if (pready) last_rdy = cyc;
      end
    end
  end

  // One APB transfer. It is entered 1 time unit after a rising edge, and the
  // setup phase is driven in that cycle. d = number of CMD cycles with
  // cmd_ready low.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input int d);
    t_t0     = cyc;
    t_d      = d;
    t_write  = w;
    t_addr   = a;
    t_data   = dat;
    t_mask   = w ? s : 4'hF;
    t_err    = (a >= 32'(ADDR_DEPTH * 4));
    t_rd     = mdl[a[9:2]];
    t_done   = t_err ? t_t0 + 1 : (w ? t_t0 + 2 + d : t_t0 + 3 + d);
    fires    = 0;
    last_rdy = -1;
    ready_at = t_t0 + 1 + d;
    act      = 1'b1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = dat; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    while (cyc < t_done) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; act = 1'b0;
    chk("fires", 32'(fires), t_err ? 32'd0 : 32'd1);
    if (w && !t_err)
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a[9:2]][8*b +: 8] = dat[8*b +: 8];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'hA5A5_A5A5 ^ 32'(i);
      mdl[i] = 32'hA5A5_A5A5 ^ 32'(i);
    end
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Masked write, then a read-back of the merged word
    xfer(1'b1, 32'h10, 32'h1234_5678, 4'b0011, 0);
    chk("wr_latency", 32'(last_rdy - t_t0), 32'd2);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("rd_latency", 32'(last_rdy - t_t0), 32'd3);
    chk("rd_lit", prdata, 32'hA5A5_5678);

    // cmd_ready held low for 5 cycles
    xfer(1'b1, 32'h24, 32'hCAFE_F00D, 4'b1001, 5);
    chk("stall_wr_latency", 32'(last_rdy - t_t0), 32'd7);
    xfer(1'b0, 32'h24, 32'h5555_AAAA, 4'h0, 2);
    chk("stall_rd_lit", prdata, 32'hCAA5_A50D);

    // Address range boundary
    xfer(1'b0, 32'h0003_FFFC, 32'h0, 4'h0, 0);
    chk("last_word_lit", prdata, 32'hA5A5_A55A);
    xfer(1'b0, 32'h0004_0000, 32'h0, 4'h0, 0);
    chk("oor_rd_lit", prdata, 32'h0);
    xfer(1'b1, 32'h0004_0000, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Reset while in RSP, with the RAM response arriving after the reset
    chk_en  = 1'b0;
    rsp_lat = 3;
    t_t0    = cyc;
    ready_at = t_t0 + 1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h24; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_prdata", prdata, 32'hA5A5_5678);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pready",    32'(pready),    32'h0);
    chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("mid_rst_prdata",    prdata,         32'h0);
    chk("mid_rst_cmd_addr",  cmd_addr,       32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    rsp_lat  = 1;
    prdata_m = 32'h0;
    act      = 1'b0;
    chk_en   = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("post_rst_rd_lit", prdata, 32'hA5A5_5678);

`ifdef APB3_RAM_BRIDGE_TIMEOUT_EN
    // Read whose response never arrives: aborted by the timeout
    begin
      int n;
      chk_en  = 1'b0;
      rsp_lat = 100000;
      t_t0    = cyc;
      ready_at = t_t0 + 1;
      psel = 1'b1; penable = 1'b0; paddr = 32'h24; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      while (!pready && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk("to_pready",  32'(pready),  32'h1);
      chk("to_pslverr", 32'(pslverr), 32'h1);
      chk("to_prdata",  prdata,       32'h0);
      chk("to_window",  32'((cyc - t_t0 >= 9) && (cyc - t_t0 <= 12)), 32'h1);
      psel = 1'b0; penable = 1'b0;
      due = cyc + 2;
      rdat = 32'h7777_7777;
      repeat (5) begin
        @(posedge clk); #1;
        chk("to_late_rsp_pready", 32'(pready), 32'h0);
        chk("to_late_rsp_prdata", prdata, 32'h0);
      end
    end
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
